// File: rtl/router_pkg.sv
// Shared constants and the framing state encoding for the router read-side blocks.
package router_pkg;

  localparam int FLIT_W_DEF = 8;
  localparam int LEN_W_DEF  = 3;
  localparam int CNT_W_DEF  = 16;

  // The header length field sits in the top bits of a flit.
  localparam int LEN_MSB = FLIT_W_DEF - 1;
  localparam int LEN_LSB = FLIT_W_DEF - LEN_W_DEF;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } deq_state_e;

endpackage

// File: rtl/flit_skid_buf.sv
// Two-entry flit FIFO that absorbs the FIFO memory read latency.
module flit_skid_buf
  import router_pkg::*;
#(
  parameter int W = FLIT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [1:0]   o_occ,
  output logic [W-1:0] o_head_data
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides what is valid,
  // so only the pointers and count need a reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(i_push && r_occ == 2'd2));
      assert (!(i_pop && r_occ == 2'd0));
    end
  end

  assign o_occ       = r_occ;
  assign o_head_data = (r_occ != 2'd0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fifo_flit_dequeue.sv
// Read-side consumer of the async input FIFO: credit-based pop, skid buffering,
// valid/ready output stream with sop/eop framing and a completed-packet counter.
module fifo_flit_dequeue
  import router_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en,
  output logic              rinc,
  input  logic [FLIT_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [CNT_W-1:0]  pkt_cnt
);

  logic              r_inflight;
  deq_state_e        r_state;
  deq_state_e        w_state_nxt;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  w_remaining_nxt;
  logic [CNT_W-1:0]  r_pkt_cnt;
  logic              w_cnt_inc;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic [FLIT_W-1:0] w_head;
  logic [LEN_W-1:0]  w_len;
  logic [2:0]        w_credit_use;

  flit_skid_buf #(.W(FLIT_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data (rdata),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head_data (w_head)
  );

  assign out_valid = (w_occ != 2'd0);
  assign out_data  = w_head;
  assign w_pop     = out_valid & out_ready;
  assign w_len     = w_head[FLIT_W-1 -: LEN_W];

  // Slots already committed after this cycle's pop; an in-flight read owns a slot.
  assign w_credit_use = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign rinc         = read_en & rst & (w_credit_use < 3'd2);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inflight  <= 1'b0;
      r_state     <= HEAD;
      r_remaining <= '0;
      r_pkt_cnt   <= '0;
    end else begin
      r_inflight  <= rinc;
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      if (w_cnt_inc) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_cnt_inc       = 1'b0;
    out_sop         = 1'b0;
    out_eop         = 1'b0;
    case (r_state)
      HEAD: begin
        out_sop = out_valid;
        if (w_len == '0) begin
          out_eop   = out_valid;
          w_cnt_inc = w_pop;
        end else if (w_pop) begin
          w_state_nxt     = BODY;
          w_remaining_nxt = w_len;
        end
      end
      BODY: begin
        out_eop = out_valid && (r_remaining == LEN_W'(1));
        if (w_pop) begin
          w_remaining_nxt = r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            w_state_nxt = HEAD;
            w_cnt_inc   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign pkt_cnt = r_pkt_cnt;

endmodule
